dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Sequences the single data-cache port between two requesters: load requests from the load/store reservation station and store commits from the reorder buffer.
It grants one requester at a time and latches that request's address, data and byte enable. It drives the cache until mem_resp, then returns the response to the granted side.
The arbiter replaces ad-hoc muxing of the data port at the CPU top level. Loads affected by a branch/jalr flush are dropped cleanly.

Parameters:
ADDR_W, 32, address width (rv32i_word)
DATA_W, 32, data width (rv32i_word)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  ROB mispredict flush; kills pending/in-flight load response
ld_req  in  1  load request; held with ld_addr until ld_ack or flush
ld_addr  in  ADDR_W  load address (word-aligned)
ld_ack  out  1  one-cycle pulse: load data valid
ld_rdata  out  DATA_W  load data, valid when ld_ack
st_req  in  1  store commit request; held with fields until st_ack
st_addr  in  ADDR_W  store address
st_wdata  in  DATA_W  store data
st_be  in  4  store byte enable
st_ack  out  1  one-cycle pulse: store written
mem_read  out  1  data-cache read
mem_write  out  1  data-cache write
mem_address  out  ADDR_W  data-cache address
mem_wdata  out  DATA_W  data-cache write data
mem_byte_enable  out  4  data-cache byte enable
mem_rdata  in  DATA_W  data-cache read data
mem_resp  in  1  data-cache completion

Behaviour:
- States: IDLE, LOAD, STORE.
- Reset (async): state=IDLE, last_grant=LOAD (so a store wins the first tie), drop=0, latched addr/wdata/be=0.
- Reset values of outputs: all outputs 0.
- IDLE:
  - Only st_req -> STORE.
  - Only ld_req and !flush -> LOAD.
  - Both requesting -> grant the side not in last_grant (round-robin).
  - ld_req with flush in the same cycle is ignored; a simultaneous st_req is still granted.
  - On grant: latch address/wdata/be (loads use be=4'hF, wdata=0) and update last_grant.
- Timing: request to mem_read/mem_write is 1 cycle; both are registered from state.
- Outputs by state:
  - LOAD: mem_read=1.
  - STORE: mem_write=1.
  - mem_address, mem_wdata and mem_byte_enable come from the latches and are stable for the whole transaction.
  - mem_read and mem_write are never both 1.
- LOAD/STORE on mem_resp: next state IDLE.
  - The ack is combinational in the mem_resp cycle: ld_ack = mem_resp & LOAD & !drop & !flush; ld_rdata = mem_rdata.
  - st_ack = mem_resp & STORE.
- Minimum one IDLE cycle between transactions; back-to-back throughput is 1 transaction per (cache latency + 1) cycles.
- Flush:
  - In LOAD: set drop. The read is NOT aborted; mem_read stays high until mem_resp, and no ld_ack is issued. drop clears on return to IDLE.
  - In STORE: no effect; committed stores always complete and ack.
- mem_resp while IDLE is ignored (no ack).
- Reset mid-transaction returns to IDLE immediately and deasserts mem_read/mem_write.
- No starvation: with both requesters continuously asserting, grants strictly alternate.

Test Plan:
- Reset, then st_req addr=0x100 wdata=0xDEADBEEF be=4'b0011, cache resp after 3 cycles -> mem_write high from cycle 1, addr/wdata/be stable; st_ack pulses in the resp cycle; mem_read never high.
- ld_req addr=0x200, mem_rdata=0x12345678 on resp -> mem_read high with be=4'hF; ld_ack 1 cycle with ld_rdata=0x12345678; one IDLE cycle follows.
- ld_req and st_req both asserted continuously for 4 transactions from reset -> grant order STORE, LOAD, STORE, LOAD; mem_read/mem_write never overlap.
- Flush 1 cycle after LOAD grant for addr=0x300 -> mem_read held until mem_resp, no ld_ack; a st_req pending alongside is granted next.
- Flush in STORE -> store completes and st_ack still pulses.
- ld_req+flush same cycle in IDLE -> no grant, mem_read stays 0.
- rst asserted mid-STORE (asynchronously, not on a clock edge) -> mem_write drops immediately, state IDLE, no st_ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data-cache port between loads and store commits
// Latches the granted request and drives the cache until mem_resp; flushed loads complete silently.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_wdata,
   input  logic [3:0]        st_be,
   output logic              st_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_byte_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   logic [1:0]        state;
   logic              last_store;
   logic              drop;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;

   logic ld_ok;
   logic grant_st;
   logic grant_ld;

   // A load that coincides with a flush is already dead and never competes.
   assign ld_ok    = ld_req & ~flush;
   assign grant_st = (state == IDLE) & st_req & (~ld_ok | ~last_store);
   assign grant_ld = (state == IDLE) & ld_ok & ~grant_st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_store <= 1'b0;
         drop       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (grant_st) begin
                  state      <= STORE;
                  last_store <= 1'b1;
                  addr_q     <= st_addr;
                  wdata_q    <= st_wdata;
                  be_q       <= st_be;
               end else if (grant_ld) begin
                  state      <= LOAD;
                  last_store <= 1'b0;
                  addr_q     <= ld_addr;
                  wdata_q    <= '0;
                  be_q       <= 4'hF;
               end
            end
            LOAD: begin
               // The read runs to completion; drop only suppresses its ack.
               if (mem_resp) begin
                  state <= IDLE;
                  drop  <= 1'b0;
               end else if (flush) begin
                  drop <= 1'b1;
               end
            end
            STORE: begin
               if (mem_resp) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               drop  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_read        = (state == LOAD);
   assign mem_write       = (state == STORE);
   assign mem_address     = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_byte_enable = be_q;

   assign ld_ack   = mem_resp & (state == LOAD) & ~drop & ~flush;
   assign ld_rdata = ld_ack ? mem_rdata : '0;
   assign st_ack   = mem_resp & (state == STORE);

endmodule
